// File: rtl/banco_registros_scan_pkg.sv
// Shared widths and types for the scanned register bank.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package banco_pkg;

    localparam int BIT_ADDR_DEF = 2;
    localparam int BIT_DATO_DEF = 4;
    localparam int NUM_REG      = 1 << BIT_ADDR_DEF;

    typedef logic [BIT_ADDR_DEF-1:0] addr_t;
    typedef logic [BIT_DATO_DEF-1:0] dato_t;

endpackage

// File: rtl/banco_registros_scan_if.sv
// Bus bundle between the datapath/display side and the register bank.
// Latency: none (wiring only).
// Backpressure: none; the scan channel is paced only by iScanEn.
interface banco_registros_scan_if
    import banco_pkg::*;
#(
    parameter int BIT_ADDR = BIT_ADDR_DEF,
    parameter int BIT_DATO = BIT_DATO_DEF
);
    logic                iWrEn;
    logic [BIT_ADDR-1:0] iAddrW;
    logic [BIT_DATO-1:0] iDatoW;
    logic [BIT_ADDR-1:0] iAddrR1;
    logic [BIT_ADDR-1:0] iAddrR2;
    logic [BIT_DATO-1:0] oSalida_1;
    logic [BIT_DATO-1:0] oSalida_2;
    logic                iScanEn;
    logic [BIT_ADDR-1:0] oScanAddr;
    logic [BIT_DATO-1:0] oScanDato;
    logic                oScanValid;

    // Datapath / display side.
    modport master (
        output iWrEn, iAddrW, iDatoW, iAddrR1, iAddrR2, iScanEn,
        input  oSalida_1, oSalida_2, oScanAddr, oScanDato, oScanValid
    );

    // Register bank side.
    modport slave (
        input  iWrEn, iAddrW, iDatoW, iAddrR1, iAddrR2, iScanEn,
        output oSalida_1, oSalida_2, oScanAddr, oScanDato, oScanValid
    );
endinterface

// File: rtl/banco_registros_scan_scan_puntero.sv
// Scan walk pointer with registered entry address and valid flag.
// Latency: one cycle from en to valid/addr.
// Backpressure: none; en=0 freezes the pointer and address, drops valid.
module scan_puntero #(
    parameter int BIT_ADDR = 2
) (
    input  logic                iClk,
    input  logic                rst,
    input  logic                en,
    output logic [BIT_ADDR-1:0] ptr,
    output logic [BIT_ADDR-1:0] addr,
    output logic                valid
);

    // Advance the walk on each enabled edge; wrap is the natural overflow.
    always_ff @(posedge iClk) begin
        if (!rst) begin
            ptr   <= '0;
            addr  <= '0;
            valid <= 1'b0;
        end else if (en) begin
            ptr   <= ptr + BIT_ADDR'(1);
            addr  <= ptr;
            valid <= 1'b1;
        end else begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/banco_registros_scan.sv
// Register file with one write port, two bypassed read ports and a scan channel.
// Latency: reads combinational (write-first); scan entry one cycle after enable.
// Backpressure: none; scan advances only on iScanEn, writes accepted every cycle.
module banco_registros_scan
    import banco_pkg::*;
#(
    parameter int BIT_ADDR = BIT_ADDR_DEF,
    parameter int BIT_DATO = BIT_DATO_DEF,
    parameter int ZERO_REG = 0
) (
    input  logic iClk,
    input  logic rst,
    banco_registros_scan_if.slave bus
);

    localparam int NREG = 1 << BIT_ADDR;

    logic [BIT_DATO-1:0] mem [NREG];
    logic                wr_ok;
    logic [BIT_DATO-1:0] rd1;
    logic [BIT_DATO-1:0] rd2;
    logic [BIT_ADDR-1:0] scan_ptr;
    logic [BIT_ADDR-1:0] scan_addr;
    logic                scan_valid;
    logic [BIT_DATO-1:0] scan_dato;

    // A write only lands outside reset and never on a hardwired-zero register 0;
    // the bypass uses the same qualifier so reads never show a discarded write.
    assign wr_ok = rst && bus.iWrEn
                   && !((ZERO_REG != 0) && (bus.iAddrW == '0));

    // Storage array: cleared by reset, one write per edge.
    always_ff @(posedge iClk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[bus.iAddrW] <= bus.iDatoW;
        end
    end

    // Read port 1: stored value, overridden by same-cycle write, then by zero-reg.
    always_comb begin
        rd1 = mem[bus.iAddrR1];
        if (wr_ok && (bus.iAddrR1 == bus.iAddrW)) begin
            rd1 = bus.iDatoW;
        end
        if ((ZERO_REG != 0) && (bus.iAddrR1 == '0)) begin
            rd1 = '0;
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        rd2 = mem[bus.iAddrR2];
        if (wr_ok && (bus.iAddrR2 == bus.iAddrW)) begin
            rd2 = bus.iDatoW;
        end
        if ((ZERO_REG != 0) && (bus.iAddrR2 == '0)) begin
            rd2 = '0;
        end
    end

    scan_puntero #(
        .BIT_ADDR (BIT_ADDR)
    ) u_scan_puntero (
        .iClk  (iClk),
        .rst   (rst),
        .en    (bus.iScanEn),
        .ptr   (scan_ptr),
        .addr  (scan_addr),
        .valid (scan_valid)
    );

    // Scan data captures the pre-edge stored value; a same-edge write is
    // deliberately not bypassed and shows up on the next pass.
    always_ff @(posedge iClk) begin
        if (!rst) begin
            scan_dato <= '0;
        end else if (bus.iScanEn) begin
            scan_dato <= mem[scan_ptr];
        end
    end

    assign bus.oSalida_1  = rd1;
    assign bus.oSalida_2  = rd2;
    assign bus.oScanAddr  = scan_addr;
    assign bus.oScanDato  = scan_dato;
    assign bus.oScanValid = scan_valid;

endmodule

// File: tb/tb_banco_registros_scan.sv
// Bench for banco_registros_scan: table of vectors plus hand sequences.
// Latency: checks reads before the edge, scan outputs 1 time unit after it.
// Backpressure: not applicable.
module tb_banco_registros_scan;
    import banco_pkg::*;

    logic iClk;
    logic rst_a;
    logic rst_b;

    int n_checks;
    int n_fail;

    banco_registros_scan_if #(.BIT_ADDR(2), .BIT_DATO(4)) bus_a ();
    banco_registros_scan_if #(.BIT_ADDR(2), .BIT_DATO(4)) bus_b ();

    banco_registros_scan #(.BIT_ADDR(2), .BIT_DATO(4), .ZERO_REG(0)) dut_a (
        .iClk (iClk),
        .rst  (rst_a),
        .bus  (bus_a)
    );

    banco_registros_scan #(.BIT_ADDR(2), .BIT_DATO(4), .ZERO_REG(1)) dut_b (
        .iClk (iClk),
        .rst  (rst_b),
        .bus  (bus_b)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    typedef struct {
        logic  wr;
        addr_t aw;
        dato_t dw;
        addr_t r1;
        addr_t r2;
        logic  sc;
        dato_t e1;
        dato_t e2;
        logic  ev;
        addr_t ea;
        dato_t ed;
    } vec_t;

    vec_t tbl [21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic drive_a(input logic wr, input addr_t aw, input dato_t dw,
                           input addr_t r1, input addr_t r2, input logic sc);
        bus_a.iWrEn   = wr;
        bus_a.iAddrW  = aw;
        bus_a.iDatoW  = dw;
        bus_a.iAddrR1 = r1;
        bus_a.iAddrR2 = r2;
        bus_a.iScanEn = sc;
    endtask

    task automatic drive_b(input logic wr, input addr_t aw, input dato_t dw,
                           input addr_t r1, input addr_t r2, input logic sc);
        bus_b.iWrEn   = wr;
        bus_b.iAddrW  = aw;
        bus_b.iDatoW  = dw;
        bus_b.iAddrR1 = r1;
        bus_b.iAddrR2 = r2;
        bus_b.iScanEn = sc;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        //        wr  aw  dw     r1  r2  sc  e1     e2     ev  ea  ed
        tbl[0]  = '{1, 0, 4'h3,  0,  1,  0, 4'h3,  4'h0,  0,  0, 4'h0};
        tbl[1]  = '{1, 1, 4'h5,  0,  1,  0, 4'h3,  4'h5,  0,  0, 4'h0};
        tbl[2]  = '{1, 2, 4'hC,  1,  2,  0, 4'h5,  4'hC,  0,  0, 4'h0};
        tbl[3]  = '{1, 3, 4'hF,  2,  3,  0, 4'hC,  4'hF,  0,  0, 4'h0};
        tbl[4]  = '{0, 0, 4'h0,  2,  3,  0, 4'hC,  4'hF,  0,  0, 4'h0};
        tbl[5]  = '{0, 0, 4'h0,  1,  1,  0, 4'h5,  4'h5,  0,  0, 4'h0};
        tbl[6]  = '{1, 2, 4'h7,  2,  1,  0, 4'h7,  4'h5,  0,  0, 4'h0};
        tbl[7]  = '{0, 0, 4'h0,  2,  0,  0, 4'h7,  4'h3,  0,  0, 4'h0};
        tbl[8]  = '{1, 2, 4'hC,  2,  2,  0, 4'hC,  4'hC,  0,  0, 4'h0};
        tbl[9]  = '{0, 0, 4'h0,  3,  3,  1, 4'hF,  4'hF,  1,  0, 4'h3};
        tbl[10] = '{0, 0, 4'h0,  0,  1,  1, 4'h3,  4'h5,  1,  1, 4'h5};
        tbl[11] = '{0, 0, 4'h0,  0,  1,  1, 4'h3,  4'h5,  1,  2, 4'hC};
        tbl[12] = '{0, 0, 4'h0,  0,  1,  1, 4'h3,  4'h5,  1,  3, 4'hF};
        tbl[13] = '{0, 0, 4'h0,  0,  1,  1, 4'h3,  4'h5,  1,  0, 4'h3};
        tbl[14] = '{0, 0, 4'h0,  0,  1,  1, 4'h3,  4'h5,  1,  1, 4'h5};
        tbl[15] = '{0, 0, 4'h0,  0,  3,  0, 4'h3,  4'hF,  0,  1, 4'h5};
        tbl[16] = '{1, 2, 4'h9,  2,  2,  1, 4'h9,  4'h9,  1,  2, 4'hC};
        tbl[17] = '{0, 0, 4'h0,  2,  0,  1, 4'h9,  4'h3,  1,  3, 4'hF};
        tbl[18] = '{0, 0, 4'h0,  2,  0,  1, 4'h9,  4'h3,  1,  0, 4'h3};
        tbl[19] = '{0, 0, 4'h0,  2,  0,  1, 4'h9,  4'h3,  1,  1, 4'h5};
        tbl[20] = '{0, 0, 4'h0,  2,  2,  1, 4'h9,  4'h9,  1,  2, 4'h9};

        // Reset held for two edges while a write and scan are requested.
        rst_a = 1'b0;
        rst_b = 1'b0;
        drive_a(1'b1, 2'd1, 4'hA, 2'd1, 2'd0, 1'b1);
        drive_b(1'b0, 2'd0, 4'h0, 2'd0, 2'd0, 1'b0);
        step();
        step();
        #2;
        check("rst_rd1_a1", bus_a.oSalida_1, 4'h0);
        check("rst_rd2_a0", bus_a.oSalida_2, 4'h0);
        check("rst_scan_valid", bus_a.oScanValid, 1'b0);
        check("rst_scan_addr", bus_a.oScanAddr, 2'd0);
        check("rst_scan_dato", bus_a.oScanDato, 4'h0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        drive_a(1'b0, 2'd0, 4'h0, 2'd1, 2'd3, 1'b0);
        #2;
        check("post_rst_rd1", bus_a.oSalida_1, 4'h0);
        check("post_rst_rd2", bus_a.oSalida_2, 4'h0);

        // Table: write/read, bypass, scan wrap, scan/write collision.
        for (int i = 0; i < 21; i++) begin
            drive_a(tbl[i].wr, tbl[i].aw, tbl[i].dw, tbl[i].r1, tbl[i].r2, tbl[i].sc);
            #2;
            check($sformatf("v%0d_rd1", i), bus_a.oSalida_1, tbl[i].e1);
            check($sformatf("v%0d_rd2", i), bus_a.oSalida_2, tbl[i].e2);
            step();
            check($sformatf("v%0d_scan_valid", i), bus_a.oScanValid, tbl[i].ev);
            check($sformatf("v%0d_scan_addr", i), bus_a.oScanAddr, tbl[i].ea);
            check($sformatf("v%0d_scan_dato", i), bus_a.oScanDato, tbl[i].ed);
        end
        drive_a(1'b0, 2'd0, 4'h0, 2'd0, 2'd0, 1'b0);

        // ZERO_REG=1: normal register works, register 0 stays zero.
        drive_b(1'b1, 2'd1, 4'h6, 2'd1, 2'd1, 1'b0);
        #2;
        check("z_bypass_r1", bus_b.oSalida_1, 4'h6);
        step();
        drive_b(1'b1, 2'd0, 4'hE, 2'd0, 2'd0, 1'b0);
        #2;
        check("z_wr0_during_rd1", bus_b.oSalida_1, 4'h0);
        check("z_wr0_during_rd2", bus_b.oSalida_2, 4'h0);
        step();
        drive_b(1'b0, 2'd0, 4'h0, 2'd0, 2'd1, 1'b0);
        #2;
        check("z_wr0_after", bus_b.oSalida_1, 4'h0);
        check("z_r1_held", bus_b.oSalida_2, 4'h6);

        // Scan on the zero-reg bank, then reset in the middle of the walk.
        drive_b(1'b0, 2'd0, 4'h0, 2'd0, 2'd1, 1'b1);
        step();
        check("z_scan0_valid", bus_b.oScanValid, 1'b1);
        check("z_scan0_addr", bus_b.oScanAddr, 2'd0);
        check("z_scan0_dato", bus_b.oScanDato, 4'h0);
        step();
        check("z_scan1_addr", bus_b.oScanAddr, 2'd1);
        check("z_scan1_dato", bus_b.oScanDato, 4'h6);
        step();
        check("z_scan2_addr", bus_b.oScanAddr, 2'd2);
        rst_b = 1'b0;
        step();
        check("z_midrst_valid", bus_b.oScanValid, 1'b0);
        check("z_midrst_addr", bus_b.oScanAddr, 2'd0);
        check("z_midrst_rd2", bus_b.oSalida_2, 4'h0);
        rst_b = 1'b1;
        step();
        check("z_restart_valid", bus_b.oScanValid, 1'b1);
        check("z_restart_addr", bus_b.oScanAddr, 2'd0);
        check("z_restart_dato", bus_b.oScanDato, 4'h0);
        step();
        check("z_restart_next_addr", bus_b.oScanAddr, 2'd1);
        check("z_restart_next_dato", bus_b.oScanDato, 4'h0);
        drive_b(1'b0, 2'd0, 4'h0, 2'd0, 2'd0, 1'b0);
        step();
        check("z_scan_off_valid", bus_b.oScanValid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
